// File: rtl/xor_frame_accumulator.sv
// xor_frame_accumulator: folds a valid/ready stream of WIDTH-bit words into one
// XOR word, parity bit, word count and forced-close flag per frame.
// A frame closes on in_last or after MAX_LEN words; one result is held until taken.
// Optional feature: define PARITY_CHECK_EN to add exp_parity/out_err.
module xor_frame_accumulator #(
    parameter int unsigned WIDTH   = 2,
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned CNT_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_word,
    output logic             out_parity,
    output logic [CNT_W-1:0] out_count,
    output logic             out_forced
`ifdef PARITY_CHECK_EN
    ,
    input  logic             exp_parity,
    output logic             out_err
`endif
);

    typedef enum logic {StAcc, StHold} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   out_word_q, out_word_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;
    logic               out_forced_q, out_forced_d;
`ifdef PARITY_CHECK_EN
    logic               out_err_q, out_err_d;
`endif

    logic               accept;
    logic               close;
    logic [WIDTH-1:0]   acc_next;
    logic [CNT_W-1:0]   cnt_next;

    // Next-state: accumulate in StAcc, latch result on close, release on handshake
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        count_d      = count_q;
        out_word_d   = out_word_q;
        out_count_d  = out_count_q;
        out_forced_d = out_forced_q;
`ifdef PARITY_CHECK_EN
        out_err_d    = out_err_q;
`endif
        // in_ready is forced low during reset so nothing is accepted then
        in_ready  = (state_q == StAcc) && !rst;
        out_valid = (state_q == StHold);
        accept    = in_valid && in_ready;
        acc_next  = acc_q ^ in_data;
        cnt_next  = count_q + CNT_W'(1);
        // count_q never reaches MAX_LEN in StAcc, so cnt_next cannot wrap
        close     = in_last || (cnt_next == CNT_W'(MAX_LEN));

        unique case (state_q)
            StAcc: begin
                if (accept) begin
                    if (close) begin
                        out_word_d   = acc_next;
                        out_count_d  = cnt_next;
                        out_forced_d = !in_last;
`ifdef PARITY_CHECK_EN
                        out_err_d    = (^acc_next) != exp_parity;
`endif
                        acc_d        = '0;
                        count_d      = '0;
                        state_d      = StHold;
                    end else begin
                        acc_d   = acc_next;
                        count_d = cnt_next;
                    end
                end
            end
            StHold: begin
                if (out_ready) begin
                    state_d = StAcc;
                end
            end
            default: state_d = StAcc;
        endcase
    end

    // State and result registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StAcc;
            acc_q        <= '0;
            count_q      <= '0;
            out_word_q   <= '0;
            out_count_q  <= '0;
            out_forced_q <= 1'b0;
`ifdef PARITY_CHECK_EN
            out_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            count_q      <= count_d;
            out_word_q   <= out_word_d;
            out_count_q  <= out_count_d;
            out_forced_q <= out_forced_d;
`ifdef PARITY_CHECK_EN
            out_err_q    <= out_err_d;
`endif
        end
    end

    assign out_word   = out_word_q;
    assign out_parity = ^out_word_q;
    assign out_count  = out_count_q;
    assign out_forced = out_forced_q;
`ifdef PARITY_CHECK_EN
    assign out_err    = out_err_q;
`endif

endmodule

// File: tb/tb_xor_frame_accumulator.sv
// Directed, table-driven bench for xor_frame_accumulator (WIDTH=2, MAX_LEN=8).
module tb_xor_frame_accumulator;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_word;
    logic       out_parity;
    logic [3:0] out_count;
    logic       out_forced;
`ifdef PARITY_CHECK_EN
    logic       exp_parity;
    logic       out_err;
`endif

    int checks = 0;
    int errors = 0;

    xor_frame_accumulator #(
        .WIDTH   (2),
        .MAX_LEN (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_word   (out_word),
        .out_parity (out_parity),
        .out_count  (out_count),
        .out_forced (out_forced)
`ifdef PARITY_CHECK_EN
        ,
        .exp_parity (exp_parity),
        .out_err    (out_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] data;
        logic       last;
        logic       res;     // this word closes a frame
        logic [1:0] word;
        logic       par;
        logic [3:0] cnt;
        logic       forced;
    } vec_t;

    vec_t vecs[24];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at posedge+1; offers a word and returns at posedge+1 after acceptance
    task automatic send_word(input logic [1:0] d, input logic l);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready got 0 expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 2'b00;
        in_last = 1'b0;
        out_ready = 1'b0;
`ifdef PARITY_CHECK_EN
        exp_parity = 1'b0;
`endif

        // Truth table frames
        vecs[0]  = '{2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 4'd1, 1'b0};
        vecs[1]  = '{2'b01, 1'b1, 1'b1, 2'b01, 1'b1, 4'd1, 1'b0};
        vecs[2]  = '{2'b10, 1'b1, 1'b1, 2'b10, 1'b1, 4'd1, 1'b0};
        vecs[3]  = '{2'b11, 1'b1, 1'b1, 2'b11, 1'b0, 4'd1, 1'b0};
        // Three-word frame 01^10^11 = 00
        vecs[4]  = '{2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 4'd0, 1'b0};
        vecs[5]  = '{2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 4'd0, 1'b0};
        vecs[6]  = '{2'b11, 1'b1, 1'b1, 2'b00, 1'b0, 4'd3, 1'b0};
        // Nine 01 words: forced close at 8, then 9th word with last
        for (int i = 7; i < 14; i++) vecs[i] = '{2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 4'd0, 1'b0};
        vecs[14] = '{2'b01, 1'b0, 1'b1, 2'b00, 1'b0, 4'd8, 1'b1};
        vecs[15] = '{2'b01, 1'b1, 1'b1, 2'b01, 1'b1, 4'd1, 1'b0};
        // in_last on word 8: eight 11 words -> 00, normal close
        for (int i = 16; i < 23; i++) vecs[i] = '{2'b11, 1'b0, 1'b0, 2'b00, 1'b0, 4'd0, 1'b0};
        vecs[23] = '{2'b11, 1'b1, 1'b1, 2'b00, 1'b0, 4'd8, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        rst = 1'b0;
        #1;
        check("rst_in_ready_after", {31'b0, in_ready}, 32'd1);
        check("rst_out_word", {30'b0, out_word}, 32'd0);
        check("rst_out_parity", {31'b0, out_parity}, 32'd0);
        check("rst_out_count", {28'b0, out_count}, 32'd0);
        check("rst_out_forced", {31'b0, out_forced}, 32'd0);
`ifdef PARITY_CHECK_EN
        check("rst_out_err", {31'b0, out_err}, 32'd0);
`endif

        // Table-driven frames
        for (int i = 0; i < 24; i++) begin
            send_word(vecs[i].data, vecs[i].last);
            check($sformatf("vec%0d out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].res});
            check($sformatf("vec%0d in_ready", i), {31'b0, in_ready}, {31'b0, !vecs[i].res});
            if (vecs[i].res) begin
                check($sformatf("vec%0d word", i), {30'b0, out_word}, {30'b0, vecs[i].word});
                check($sformatf("vec%0d parity", i), {31'b0, out_parity}, {31'b0, vecs[i].par});
                check($sformatf("vec%0d count", i), {28'b0, out_count}, {28'b0, vecs[i].cnt});
                check($sformatf("vec%0d forced", i), {31'b0, out_forced},
                      {31'b0, vecs[i].forced});
                take_result();
                check($sformatf("vec%0d released", i), {31'b0, out_valid}, 32'd0);
                check($sformatf("vec%0d hold_word", i), {30'b0, out_word},
                      {30'b0, vecs[i].word});
            end
        end

        // Backpressure: result held 5 cycles while a word waits at the input
        send_word(2'b01, 1'b1);
        in_valid = 1'b1;
        in_data  = 2'b10;
        in_last  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check("bp_out_valid", {31'b0, out_valid}, 32'd1);
            check("bp_in_ready", {31'b0, in_ready}, 32'd0);
            check("bp_word", {30'b0, out_word}, 32'd1);
            check("bp_count", {28'b0, out_count}, 32'd1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_release_valid", {31'b0, out_valid}, 32'd0);
        check("bp_release_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("bp_next_valid", {31'b0, out_valid}, 32'd1);
        check("bp_next_word", {30'b0, out_word}, 32'd2);
        check("bp_next_count", {28'b0, out_count}, 32'd1);
        take_result();

        // Reset mid-frame discards the partial accumulation
        send_word(2'b01, 1'b0);
        send_word(2'b10, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_out_count", {28'b0, out_count}, 32'd0);
        send_word(2'b11, 1'b1);
        check("post_rst_valid", {31'b0, out_valid}, 32'd1);
        check("post_rst_word", {30'b0, out_word}, 32'd3);
        check("post_rst_count", {28'b0, out_count}, 32'd1);
        check("post_rst_forced", {31'b0, out_forced}, 32'd0);
        take_result();

`ifdef PARITY_CHECK_EN
        exp_parity = 1'b0;
        send_word(2'b01, 1'b1);
        check("perr_mismatch", {31'b0, out_err}, 32'd1);
        take_result();
        exp_parity = 1'b1;
        send_word(2'b01, 1'b1);
        check("perr_match", {31'b0, out_err}, 32'd0);
        take_result();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
